// File: rtl/pq_pkg.sv
// Shared constants and helpers for the three-phase P/Q calculator.
package pq_pkg;

  // 1/sqrt(3) as an unsigned Q1.17 value, and the fractional bit count that
  // has to be shifted back out after multiplying by it.
  localparam int INV_SQRT3      = 75675;
  localparam int INV_SQRT3_FRAC = 17;

  // Channel tag width; a single-channel build still gets a 1-bit tag.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Clamp a wide signed value to the range of a w-bit signed number.
  // Callers detect clipping by comparing the result with the argument.
  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] x,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/pq_avg_bank.sv
// Per-channel block averager for the instantaneous P/Q results.
// Each channel sums 2^AVG_LOG samples, then emits the floor average and
// restarts. avg_clr wipes every channel and swallows any result in that cycle.
module pq_avg_bank
  import pq_pkg::*;
#(
  parameter int W       = 18,
  parameter int N_CH    = 4,
  parameter int AVG_LOG = 4,
  localparam int CH_W   = ch_width(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                avg_clr,
  input  logic                res_valid,
  input  logic [CH_W-1:0]     res_ch,
  input  logic                res_err,
  input  logic signed [W-1:0] res_p,
  input  logic signed [W-1:0] res_q,
  output logic                avg_valid,
  output logic [CH_W-1:0]     avg_ch,
  output logic signed [W-1:0] p_avg,
  output logic signed [W-1:0] q_avg
);

  localparam int AW = W + AVG_LOG;

  logic signed [AW-1:0]  acc_p [N_CH];
  logic signed [AW-1:0]  acc_q [N_CH];
  logic [AVG_LOG-1:0]    cnt   [N_CH];
  logic signed [AW-1:0]  sum_p [N_CH];
  logic signed [AW-1:0]  sum_q [N_CH];
  logic [N_CH-1:0]       hit;
  logic [N_CH-1:0]       wrap;
  logic signed [AW-1:0]  done_p;
  logic signed [AW-1:0]  done_q;

  // Decode which channel this result belongs to and whether it closes a window.
  always_comb begin
    hit    = '0;
    wrap   = '0;
    done_p = '0;
    done_q = '0;
    for (int c = 0; c < N_CH; c++) begin
      sum_p[c] = acc_p[c] + AW'(res_p);
      sum_q[c] = acc_q[c] + AW'(res_q);
      hit[c]   = res_valid && !res_err && !avg_clr && (res_ch == CH_W'(c));
      wrap[c]  = hit[c] && (cnt[c] == '1);
      if (wrap[c]) begin
        done_p = sum_p[c];
        done_q = sum_q[c];
      end
    end
  end

  // Accumulate, wrap and clear; only one channel can complete per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        acc_p[c] <= '0;
        acc_q[c] <= '0;
        cnt[c]   <= '0;
      end
      avg_valid <= 1'b0;
      avg_ch    <= '0;
      p_avg     <= '0;
      q_avg     <= '0;
    end else begin
      avg_valid <= |wrap;
      if (|wrap) begin
        avg_ch <= res_ch;
        p_avg  <= W'(done_p >>> AVG_LOG);
        q_avg  <= W'(done_q >>> AVG_LOG);
      end
      for (int c = 0; c < N_CH; c++) begin
        if (avg_clr || wrap[c]) begin
          acc_p[c] <= '0;
          acc_q[c] <= '0;
          cnt[c]   <= '0;
        end else if (hit[c]) begin
          acc_p[c] <= sum_p[c];
          acc_q[c] <= sum_q[c];
          cnt[c]   <= cnt[c] + AVG_LOG'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pq_cal_stream.sv
// Streaming three-phase active/reactive power calculator.
// Four-stage pipeline: differences, products, sums, 1/sqrt(3) scale + saturate.
// The registered results also feed the per-channel block averager.
module pq_cal_stream
  import pq_pkg::*;
#(
  parameter int W       = 18,
  parameter int FRAC    = 14,
  parameter int N_CH    = 4,
  parameter int AVG_LOG = 4,
  localparam int CH_W   = ch_width(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic signed [W-1:0] va,
  input  logic signed [W-1:0] vb,
  input  logic signed [W-1:0] vc,
  input  logic signed [W-1:0] ia,
  input  logic signed [W-1:0] ib,
  input  logic signed [W-1:0] ic,
  input  logic                avg_clr,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic signed [W-1:0] p_out,
  output logic signed [W-1:0] q_out,
  output logic                out_sat,
  output logic                out_err,
  output logic                avg_valid,
  output logic [CH_W-1:0]     avg_ch,
  output logic signed [W-1:0] p_avg,
  output logic signed [W-1:0] q_avg
);

  localparam int DW = W + 1;                  // line-to-line voltage
  localparam int PW = 2 * W + 1;              // widest product, (W+1) x W
  localparam int SW = 2 * W + 3;              // three-term sums
  localparam int QW = SW + INV_SQRT3_FRAC + 1;
  localparam logic signed [QW-1:0] K_Q = QW'(INV_SQRT3);

  logic                v_s1, v_s2, v_s3;
  logic [CH_W-1:0]     ch_s1, ch_s2, ch_s3;
  logic                err_s1, err_s2, err_s3;

  logic signed [W-1:0]  va_s1, vb_s1, vc_s1, ia_s1, ib_s1, ic_s1;
  logic signed [DW-1:0] vab_s1, vbc_s1, vca_s1;
  logic signed [PW-1:0] pa_s2, pb_s2, pc_s2, qa_s2, qb_s2, qc_s2;
  logic signed [SW-1:0] p_sum_s3, q_sum_s3;

  logic signed [QW-1:0] q_full;
  logic signed [SW-1:0] p_shift;
  logic signed [QW-1:0] q_shift;
  logic signed [63:0]   p_wide, q_wide, p_sat, q_sat;

  // S1: line-to-line differences, phase voltages and currents registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_s1 <= 1'b0; ch_s1 <= '0; err_s1 <= 1'b0;
      va_s1 <= '0; vb_s1 <= '0; vc_s1 <= '0;
      ia_s1 <= '0; ib_s1 <= '0; ic_s1 <= '0;
      vab_s1 <= '0; vbc_s1 <= '0; vca_s1 <= '0;
    end else begin
      v_s1 <= in_valid;
      if (in_valid) begin
        ch_s1  <= in_ch;
        err_s1 <= (int'(in_ch) >= N_CH);
        va_s1  <= va;
        vb_s1  <= vb;
        vc_s1  <= vc;
        ia_s1  <= ia;
        ib_s1  <= ib;
        ic_s1  <= ic;
        vab_s1 <= DW'(va) - DW'(vb);
        vbc_s1 <= DW'(vb) - DW'(vc);
        vca_s1 <= DW'(vc) - DW'(va);
      end
    end
  end

  // S2: the three P products and the three quadrature Q products.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_s2 <= 1'b0; ch_s2 <= '0; err_s2 <= 1'b0;
      pa_s2 <= '0; pb_s2 <= '0; pc_s2 <= '0;
      qa_s2 <= '0; qb_s2 <= '0; qc_s2 <= '0;
    end else begin
      v_s2 <= v_s1;
      if (v_s1) begin
        ch_s2  <= ch_s1;
        err_s2 <= err_s1;
        pa_s2  <= PW'(va_s1) * PW'(ia_s1);
        pb_s2  <= PW'(vb_s1) * PW'(ib_s1);
        pc_s2  <= PW'(vc_s1) * PW'(ic_s1);
        qa_s2  <= PW'(vbc_s1) * PW'(ia_s1);
        qb_s2  <= PW'(vca_s1) * PW'(ib_s1);
        qc_s2  <= PW'(vab_s1) * PW'(ic_s1);
      end
    end
  end

  // S3: full-precision P and Q sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_s3 <= 1'b0; ch_s3 <= '0; err_s3 <= 1'b0;
      p_sum_s3 <= '0; q_sum_s3 <= '0;
    end else begin
      v_s3 <= v_s2;
      if (v_s2) begin
        ch_s3    <= ch_s2;
        err_s3   <= err_s2;
        p_sum_s3 <= SW'(pa_s2) + SW'(pb_s2) + SW'(pc_s2);
        q_sum_s3 <= SW'(qa_s2) + SW'(qb_s2) + SW'(qc_s2);
      end
    end
  end

  // S4 datapath: scale Q by 1/sqrt(3), floor-shift both, clamp to W bits.
  always_comb begin
    q_full  = QW'(q_sum_s3) * K_Q;
    p_shift = p_sum_s3 >>> FRAC;
    q_shift = q_full >>> (FRAC + INV_SQRT3_FRAC);
    p_wide  = 64'(p_shift);
    q_wide  = 64'(q_shift);
    p_sat   = sat_to_w(p_wide, W);
    q_sat   = sat_to_w(q_wide, W);
  end

  // S4: registered results; data holds between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      p_out     <= '0;
      q_out     <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= v_s3;
      if (v_s3) begin
        out_ch  <= ch_s3;
        p_out   <= W'(p_sat);
        q_out   <= W'(q_sat);
        out_sat <= (p_sat != p_wide) || (q_sat != q_wide);
        out_err <= err_s3;
      end
    end
  end

  pq_avg_bank #(
    .W       (W),
    .N_CH    (N_CH),
    .AVG_LOG (AVG_LOG)
  ) u_avg_bank (
    .clk       (clk),
    .rst       (rst),
    .avg_clr   (avg_clr),
    .res_valid (out_valid),
    .res_ch    (out_ch),
    .res_err   (out_err),
    .res_p     (p_out),
    .res_q     (q_out),
    .avg_valid (avg_valid),
    .avg_ch    (avg_ch),
    .p_avg     (p_avg),
    .q_avg     (q_avg)
  );

endmodule

// File: tb/tb_pq_cal_stream.sv
// Directed bench for pq_cal_stream, built with three channels so that an
// out-of-range tag (3) can be presented on the 2-bit channel port.
module tb_pq_cal_stream;

  localparam int W       = 18;
  localparam int FRAC    = 14;
  localparam int N_CH    = 3;
  localparam int AVG_LOG = 4;
  localparam int CH_W    = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic [CH_W-1:0]     in_ch = '0;
  logic signed [W-1:0] va = '0, vb = '0, vc = '0, ia = '0, ib = '0, ic = '0;
  logic                avg_clr = 1'b0;
  logic                out_valid;
  logic [CH_W-1:0]     out_ch;
  logic signed [W-1:0] p_out, q_out;
  logic                out_sat, out_err;
  logic                avg_valid;
  logic [CH_W-1:0]     avg_ch;
  logic signed [W-1:0] p_avg, q_avg;

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  int n_avg  = 0;

  pq_cal_stream #(
    .W(W), .FRAC(FRAC), .N_CH(N_CH), .AVG_LOG(AVG_LOG)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch),
    .va(va), .vb(vb), .vc(vc), .ia(ia), .ib(ib), .ic(ic),
    .avg_clr(avg_clr),
    .out_valid(out_valid), .out_ch(out_ch), .p_out(p_out), .q_out(q_out),
    .out_sat(out_sat), .out_err(out_err),
    .avg_valid(avg_valid), .avg_ch(avg_ch), .p_avg(p_avg), .q_avg(q_avg)
  );

  always #5 clk = ~clk;

  // Strobe counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid) n_out++;
    if (avg_valid) n_avg++;
  end

  task automatic drive(input int ch, input int a, input int b, input int c,
                       input int x, input int y, input int z);
    @(negedge clk);
    in_valid = 1'b1;
    avg_clr  = 1'b0;
    in_ch = CH_W'(ch);
    va = W'(a); vb = W'(b); vc = W'(c);
    ia = W'(x); ib = W'(y); ic = W'(z);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      avg_clr  = 1'b0;
    end
  endtask

  task automatic test_reset;
    idle(3);
    n_chk++;
    if ({out_valid, avg_valid, out_sat, out_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, avg_valid, out_sat, out_err});
    end
    n_chk++;
    if (p_out !== 0 || q_out !== 0 || p_avg !== 0 || q_avg !== 0 || out_ch !== 0 || avg_ch !== 0) begin
      n_fail++; $display("FAIL reset_data: got p=%0d q=%0d pa=%0d qa=%0d expected all 0", p_out, q_out, p_avg, q_avg);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_unit_power;
    drive(0, 16384, 0, 0, 16384, 0, 0);
    idle(3);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: got out_valid=%b at t+3 expected 0", out_valid);
    end
    idle(1);
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL latency: got out_valid=%b at t+4 expected 1", out_valid);
    end
    n_chk++;
    if (p_out !== 16384 || q_out !== 0 || out_sat !== 1'b0 || out_ch !== 2'd0 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL unit_pq: got p=%0d q=%0d sat=%b ch=%0d err=%b expected 16384 0 0 0 0",
                         p_out, q_out, out_sat, out_ch, out_err);
    end
    idle(1);
    n_chk++;
    if (out_valid !== 1'b0 || p_out !== 16384) begin
      n_fail++; $display("FAIL hold: got valid=%b p=%0d expected 0 16384", out_valid, p_out);
    end
  endtask

  task automatic test_reactive;
    drive(0, 16384, -8192, -8192, 0, 16384, -16384);
    idle(4);
    n_chk++;
    if (out_valid !== 1'b1 || p_out !== 0 || q_out !== -28379 || out_sat !== 1'b0) begin
      n_fail++; $display("FAIL reactive: got v=%b p=%0d q=%0d sat=%b expected 1 0 -28379 0",
                         out_valid, p_out, q_out, out_sat);
    end
    idle(2);
  endtask

  task automatic test_saturate;
    drive(0, 131071, 131071, 131071, 131071, 131071, 131071);
    idle(4);
    n_chk++;
    if (p_out !== 131071 || q_out !== 0 || out_sat !== 1'b1) begin
      n_fail++; $display("FAIL saturate: got p=%0d q=%0d sat=%b expected 131071 0 1", p_out, q_out, out_sat);
    end
    idle(2);
  endtask

  task automatic test_avg_window;
    int a0;
    a0 = n_avg;
    // ch 2: P=16384, Q=-8192 each sample; ch 1: P=16384, Q=0.
    for (int i = 0; i < 16; i++) begin
      drive(2, 16384, 0, 0, 16384, 0, -14188);
      if (i < 8) drive(1, 16384, 0, 0, 16384, 0, 0);
    end
    idle(8);
    n_chk++;
    if (n_avg - a0 !== 1) begin
      n_fail++; $display("FAIL avg_count_ch2: got %0d strobes expected 1", n_avg - a0);
    end
    n_chk++;
    if (avg_ch !== 2'd2 || p_avg !== 16384 || q_avg !== -8192) begin
      n_fail++; $display("FAIL avg_ch2: got ch=%0d p=%0d q=%0d expected 2 16384 -8192", avg_ch, p_avg, q_avg);
    end
    for (int i = 0; i < 7; i++) drive(1, 16384, 0, 0, 16384, 0, 0);
    idle(8);
    n_chk++;
    if (n_avg - a0 !== 1) begin
      n_fail++; $display("FAIL avg_ch1_early: got %0d strobes expected 1", n_avg - a0);
    end
    drive(1, 16384, 0, 0, 16384, 0, 0);
    idle(4);
    n_chk++;
    if (out_valid !== 1'b1 || avg_valid !== 1'b0) begin
      n_fail++; $display("FAIL avg_timing_t4: got v=%b av=%b expected 1 0", out_valid, avg_valid);
    end
    idle(1);
    n_chk++;
    if (avg_valid !== 1'b1 || avg_ch !== 2'd1 || p_avg !== 16384 || q_avg !== 0) begin
      n_fail++; $display("FAIL avg_ch1: got av=%b ch=%0d p=%0d q=%0d expected 1 1 16384 0",
                         avg_valid, avg_ch, p_avg, q_avg);
    end
    idle(2);
  endtask

  task automatic test_avg_clr;
    int a0;
    for (int i = 0; i < 10; i++) drive(0, 131071, 131071, 131071, 131071, 131071, 131071);
    idle(5);
    a0 = n_avg;
    drive(0, 131071, 131071, 131071, 131071, 131071, 131071);
    idle(3);
    @(negedge clk);
    avg_clr = 1'b1;
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL clr_outvalid: got %b expected 1", out_valid);
    end
    @(negedge clk);
    avg_clr = 1'b0;
    n_chk++;
    if (avg_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_noavg: got %b expected 0", avg_valid);
    end
    for (int i = 0; i < 15; i++) drive(0, 16384, 0, 0, 16384, 0, 0);
    idle(8);
    n_chk++;
    if (n_avg !== a0) begin
      n_fail++; $display("FAIL clr_early: got %0d strobes expected 0", n_avg - a0);
    end
    drive(0, 16384, 0, 0, 16384, 0, 0);
    idle(5);
    n_chk++;
    if (avg_valid !== 1'b1 || avg_ch !== 2'd0 || p_avg !== 16384 || q_avg !== 0) begin
      n_fail++; $display("FAIL clr_avg: got av=%b ch=%0d p=%0d q=%0d expected 1 0 16384 0",
                         avg_valid, avg_ch, p_avg, q_avg);
    end
    idle(2);
  endtask

  task automatic test_err;
    int a0;
    a0 = n_avg;
    drive(3, 16384, 0, 0, 16384, 0, 0);
    idle(4);
    n_chk++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_ch !== 2'd3 || p_out !== 16384) begin
      n_fail++; $display("FAIL err_flag: got v=%b err=%b ch=%0d p=%0d expected 1 1 3 16384",
                         out_valid, out_err, out_ch, p_out);
    end
    for (int i = 0; i < 16; i++) drive(3, 16384, 0, 0, 16384, 0, 0);
    idle(8);
    n_chk++;
    if (n_avg !== a0) begin
      n_fail++; $display("FAIL err_noavg: got %0d strobes expected 0", n_avg - a0);
    end
  endtask

  task automatic test_reset_midstream;
    int o0;
    o0 = n_out;
    drive(0, 16384, 0, 0, 16384, 0, 0);
    drive(1, 16384, 0, 0, 16384, 0, 0);
    drive(2, 16384, 0, 0, 16384, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({out_valid, avg_valid, out_sat, out_err} !== 4'b0 || p_out !== 0 || q_out !== 0 ||
        p_avg !== 0 || q_avg !== 0 || out_ch !== 0 || avg_ch !== 0) begin
      n_fail++; $display("FAIL midrst_zero: got v=%b p=%0d q=%0d pa=%0d qa=%0d expected all 0",
                         out_valid, p_out, q_out, p_avg, q_avg);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(8);
    n_chk++;
    if (n_out !== o0) begin
      n_fail++; $display("FAIL midrst_spurious: got %0d strobes expected 0", n_out - o0);
    end
    drive(1, 16384, -8192, -8192, 0, 16384, -16384);
    idle(3);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_early: got %b expected 0", out_valid);
    end
    idle(1);
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || p_out !== 0 || q_out !== -28379) begin
      n_fail++; $display("FAIL midrst_fresh: got v=%b ch=%0d p=%0d q=%0d expected 1 1 0 -28379",
                         out_valid, out_ch, p_out, q_out);
    end
    idle(2);
  endtask

  initial begin
    test_reset;
    test_unit_power;
    test_reactive;
    test_saturate;
    test_avg_window;
    test_avg_clr;
    test_err;
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pq_cal_stream.md
# pq_cal_stream

Parametrised fixed-point three-phase active/reactive power calculator for the water-turbine plant model. Accepts one time-multiplexed sample per cycle for up to N_CH machine channels, produces instantaneous P and Q with a fixed 4-cycle pipeline, and keeps a per-channel block average over 2^AVG_LOG samples. It sits between the phase-quantity solver outputs and the controller and measurement taps.

## Interface
- W, 18: signed sample and result width.
- FRAC, 14: fractional bits, shared by inputs and outputs (1.0 = 2^FRAC).
- N_CH, 4: channel count; CH_W = max(1, clog2(N_CH)).
- AVG_LOG, 4: averaging window is 2^AVG_LOG samples per channel.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  sample strobe.
- in_ch  in  CH_W  channel tag.
- va, vb, vc, ia, ib, ic  in  W each  signed phase voltages and currents.
- avg_clr  in  1  synchronous clear of all averaging state.
- out_valid  out  1  instantaneous result strobe.
- out_ch  out  CH_W  tag of the result.
- p_out, q_out  out  W each  instantaneous P and Q.
- out_sat  out  1  P or Q saturated.
- out_err  out  1  in_ch ≥ N_CH.
- avg_valid  out  1  window-average strobe.
- avg_ch  out  CH_W  averaged channel.
- p_avg, q_avg  out  W each  window averages.

## Operation
- No backpressure. Every cycle with in_valid=1 is accepted.
- P = (va·ia + vb·ib + vc·ic) >>> FRAC.
- Q = (Vbc·ia + Vca·ib + Vab·ic)·INV_SQRT3 >>> (FRAC+17).
  - Vab = va−vb, Vbc = vb−vc, Vca = vc−va, each W+1 bits.
  - INV_SQRT3 = 75675 (1/√3 in Q1.17).
- Products and sums are kept at full precision: 2W+3 bits for the sums.
- ">>>" is an arithmetic shift, i.e. floor rounding.
- Each result is then saturated to [−2^(W−1), 2^(W−1)−1].
- out_sat is high if either P or Q was clipped.
- out_err=1 when in_ch ≥ N_CH. P and Q are still emitted, but the averager ignores the sample.
- Averager per channel: a W+AVG_LOG-bit accumulator for each of P and Q, plus an AVG_LOG-bit sample counter.
  - Each valid in-range result adds its saturated P/Q to that channel's accumulators and increments its counter.
  - When the counter wraps, meaning this is the 2^AVG_LOG-th sample:
    - p_avg = accP >>> AVG_LOG and q_avg = accQ >>> AVG_LOG, with the current sample included.
    - avg_valid pulses for one cycle with avg_ch set.
    - The channel's accumulators and counter restart at zero.
- At most one channel completes per cycle, so there is no arbitration.
- avg_clr=1 zeroes all accumulators and counters that cycle.
  - A result arriving in the same cycle is discarded from averaging, and no avg_valid is produced.
  - out_valid is unaffected.

## Timing
- Pipeline stages:
  - S1: register differences and delay the currents.
  - S2: six products.
  - S3: P sum and Q sum.
  - S4: Q constant multiply, shift, saturate, register outputs.
- in_valid at cycle t gives out_valid at t+4. Throughput is 1 sample per cycle. in_ch and the valid flag travel with the data.
- avg_valid occurs at t+5, one cycle after the completing out_valid.
- Reset values: all valid flags 0; p_out, q_out, p_avg, q_avg, out_ch, avg_ch, out_sat, out_err all 0; accumulators and counters 0.
- Reset asserted mid-stream drops all in-flight samples; there are no spurious strobes after release.
- The first out_valid after reset release follows 4 cycles after the first accepted sample.
- Data registers are enabled only on valid, so outputs hold their last value between strobes.

## Structure
- Package pq_pkg holds:
  - INV_SQRT3 and its 17-bit scale constant.
  - A saturate-to-W function.
  - The CH_W derivation.
- Sub-module pq_avg_bank holds the per-channel accumulators, counters and the wrap/clear logic. It takes the S4 outputs as input.
- The top level holds the arithmetic pipeline.

## Test plan
- va=16384, vb=vc=0, ia=16384, ib=ic=0, ch 0 → at t+4: p_out=16384, q_out=0, out_sat=0.
- va=16384, vb=vc=−8192, ia=0, ib=16384, ic=−16384 → p_out=0, q_out=−28379.
- All six inputs = 131071 → p_out=131071, q_out=0, out_sat=1.
- Averaging window, ch 2: 16 samples with P=16384 and Q=−8192, interleaved with ch 1 traffic.
  - avg_valid fires once, after the 16th ch-2 result.
  - avg_ch=2, p_avg=16384, q_avg=−8192.
  - The ch-1 counter is unaffected.
- avg_clr and error handling:
  - Send 10 ch-0 samples, pulse avg_clr with an 11th sample, then send 16 more. The average covers exactly those 16 samples.
  - in_ch=N_CH → out_err=1 and no averaging effect.
- Reset mid-stream:
  - Assert rst with 3 samples in flight → no out_valid for them, and all outputs read 0.
  - After release, a fresh sample emerges 4 cycles later.
